// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity/baud encodings common to the TX and RX
// paths, transmitter state encoding, and baud divisor / parity helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE2 = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    B2400  = 2'b00,
    B4800  = 2'b01,
    B9600  = 2'b10,
    B19200 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;

  // Clock cycles per bit, integer truncation of clk_freq/baud.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input baud_e baud);
    int unsigned div;
    div = clk_freq / 2400;
    case (baud)
      B2400:   div = clk_freq / 2400;
      B4800:   div = clk_freq / 4800;
      B9600:   div = clk_freq / 9600;
      B19200:  div = clk_freq / 19200;
      default: div = clk_freq / 2400;
    endcase
    return div;
  endfunction

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input parity_e par);
    logic p;
    p = 1'b1;
    case (par)
      PAR_ODD:  p = ~^data;
      PAR_EVEN: p = ^data;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/baud_gen_tx.sv
// Bit-period timer for the UART transmitter: emits a one-cycle bit_tick at the
// end of every DIV-cycle bit period while enabled; restart re-aligns to a new frame.
module baud_gen_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic  clock,
  input  logic  reset_n,
  input  baud_e baud,
  input  logic  restart,
  input  logic  enable,
  output logic  bit_tick
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] last;

  always_comb begin
    last     = DIV_W'(baud_div(CLK_FREQ, baud) - 32'd1);
    bit_tick = enable && (count == last);
  end

  // Reload on the bit boundary so the count never runs past DIV-1.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart || !enable) begin
      count <= '0;
    end else if (count == last) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: 8N/O/E frame (start, 8 data LSB first, parity, stop).
// Define UART_TX_TWO_STOP_EN for two stop bits (12*DIV-cycle frame).
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DIV_W    = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       tx_ready,
  output logic       active_flag,
  output logic       done_flag
);

  tx_state_e  state, state_next;
  logic [7:0] shreg, shreg_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic       par_q, par_next;
  baud_e      baud_q, baud_next;
  logic       line_next;
  logic       bit_tick;
  logic       last_stop;
  logic       accept;
`ifdef UART_TX_TWO_STOP_EN
  logic       stop_second, stop_second_next;
`endif

  baud_gen_tx #(
    .CLK_FREQ (CLK_FREQ),
    .DIV_W    (DIV_W)
  ) u_baud_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .baud     (baud_q),
    .restart  (accept),
    .enable   (state != IDLE),
    .bit_tick (bit_tick)
  );

  // The final stop cycle doubles as the hand-off cycle, so a new byte can be
  // accepted there and its start bit follows the stop bit with no idle gap.
  always_comb begin
`ifdef UART_TX_TWO_STOP_EN
    last_stop = (state == STOP) && bit_tick && stop_second;
`else
    last_stop = (state == STOP) && bit_tick;
`endif
    done_flag   = last_stop;
    tx_ready    = (state == IDLE) || last_stop;
    active_flag = (state != IDLE) && !last_stop;
    accept      = tx_start && tx_ready;
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    par_next     = par_q;
    baud_next    = baud_q;
`ifdef UART_TX_TWO_STOP_EN
    stop_second_next = stop_second;
`endif
    if (accept) begin
      state_next   = START;
      shreg_next   = data_in;
      bit_idx_next = '0;
      par_next     = parity_bit(data_in, parity_e'(parity_type));
      baud_next    = baud_e'(baud_rate);
`ifdef UART_TX_TWO_STOP_EN
      stop_second_next = 1'b0;
`endif
    end else if (bit_tick) begin
      case (state)
        START: begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
            state_next = PARITY;
          end else begin
            shreg_next   = {1'b0, shreg[7:1]};
            bit_idx_next = bit_idx + 3'd1;
          end
        end
        PARITY: state_next = STOP;
        STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          if (stop_second) begin
            state_next = IDLE;
          end else begin
            stop_second_next = 1'b1;
          end
`else
          state_next = IDLE;
`endif
        end
        default: state_next = state;
      endcase
    end
  end

  // Line value is registered from the next state so data_tx is glitch-free.
  always_comb begin
    line_next = 1'b1;
    case (state_next)
      IDLE:    line_next = 1'b1;
      START:   line_next = 1'b0;
      DATA:    line_next = shreg_next[0];
      PARITY:  line_next = par_next;
      STOP:    line_next = 1'b1;
      default: line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      par_q   <= 1'b1;
      baud_q  <= B2400;
      data_tx <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
      stop_second <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      par_q   <= par_next;
      baud_q  <= baud_next;
      data_tx <= line_next;
`ifdef UART_TX_TWO_STOP_EN
      stop_second <= stop_second_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: directed and random frames compared
// cycle by cycle against a frame-level reference model.
module tb_uart_tx_unit;

  localparam int unsigned CLK_FREQ = 96000;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic [1:0] baud_rate = 2'b00;
  logic       data_tx;
  logic       tx_ready;
  logic       active_flag;
  logic       done_flag;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clock = ~clock;

  uart_tx_unit #(
    .CLK_FREQ (CLK_FREQ),
    .DIV_W    (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .tx_start    (tx_start),
    .data_in     (data_in),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .data_tx     (data_tx),
    .tx_ready    (tx_ready),
    .active_flag (active_flag),
    .done_flag   (done_flag)
  );

  // Reference model: bit period from the baud code, parity from a ones count.
  function automatic int modelDiv(input logic [1:0] baud);
    return int'(CLK_FREQ) / (2400 << baud);
  endfunction

  function automatic logic modelParity(input logic [7:0] data, input logic [1:0] par);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(data[i]);
    if (par == 2'b01) return (ones % 2) == 0;
    if (par == 2'b10) return (ones % 2) == 1;
    return 1'b1;
  endfunction

  function automatic logic modelBit(input logic [7:0] data, input logic [1:0] par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[idx-1];
    if (idx == 9) return modelParity(data, par);
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] par, input logic [1:0] baud);
    tx_start    = 1'b1;
    data_in     = data;
    parity_type = par;
    baud_rate   = baud;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput("idle data_tx", data_tx, 1);
      checkOutput("idle tx_ready", tx_ready, 1);
      checkOutput("idle active_flag", active_flag, 0);
      checkOutput("idle done_flag", done_flag, 0);
    end
  endtask

  // Called in the accept cycle; returns in the done cycle of the frame.
  // Inputs are scrambled while busy to show only the accepted values matter.
  task automatic runFrame(input logic [7:0] data, input logic [1:0] par, input logic [1:0] baud,
                          input bit keepStart, input logic [7:0] busyData);
    int div;
    int n;
    div = modelDiv(baud);
    n   = (10 + STOP_BITS) * div;
    checkOutput("tx_ready at accept", tx_ready, 1);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) begin
        if (!keepStart) tx_start = 1'b0;
        data_in     = keepStart ? busyData : 8'($urandom);
        parity_type = 2'($urandom);
        baud_rate   = 2'($urandom);
      end
      checkOutput($sformatf("data_tx d=%0h k=%0d", data, k), data_tx, modelBit(data, par, (k - 1) / div));
      checkOutput($sformatf("active_flag k=%0d", k), active_flag, k < n);
      checkOutput($sformatf("done_flag k=%0d", k), done_flag, k == n);
      checkOutput($sformatf("tx_ready k=%0d", k), tx_ready, k == n);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] p;
    logic [1:0] b;

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    checkOutput("reset data_tx", data_tx, 1);
    checkOutput("reset tx_ready", tx_ready, 1);
    checkOutput("reset active_flag", active_flag, 0);
    checkOutput("reset done_flag", done_flag, 0);
    reset_n = 1'b1;
    idleCycles(3);

    // Single byte 0xA5, odd parity, 9600 (DIV=10)
    applyStimulus(8'hA5, 2'b01, 2'b10);
    runFrame(8'hA5, 2'b01, 2'b10, 1'b0, 8'h00);
    idleCycles(2);

    // Parity modes on 0x07
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h07, 2'(i), 2'b11);
      runFrame(8'h07, 2'(i), 2'b11, 1'b0, 8'h00);
      idleCycles(1);
    end

    // Baud inputs move while busy; next frame uses the new rate
    applyStimulus(8'h5A, 2'b10, 2'b10);
    runFrame(8'h5A, 2'b10, 2'b10, 1'b0, 8'h00);
    applyStimulus(8'hC3, 2'b00, 2'b11);
    runFrame(8'hC3, 2'b00, 2'b11, 1'b0, 8'h00);
    idleCycles(2);

    // Back-to-back with tx_start held through the first frame
    applyStimulus(8'h00, 2'b10, 2'b11);
    runFrame(8'h00, 2'b10, 2'b11, 1'b1, 8'hFF);
    applyStimulus(8'hFF, 2'b01, 2'b11);
    runFrame(8'hFF, 2'b01, 2'b11, 1'b0, 8'h00);
    idleCycles(2);

    // Random frames, sometimes chained
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      p = 2'($urandom);
      b = 2'($urandom);
      applyStimulus(d, p, b);
      runFrame(d, p, b, 1'b0, 8'h00);
      if ($urandom_range(0, 1) == 0) idleCycles(int'($urandom_range(1, 3)));
    end
    idleCycles(2);

    // Reset in the middle of DATA
    applyStimulus(8'h3C, 2'b10, 2'b10);
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 1) tx_start = 1'b0;
    end
    checkOutput("mid-frame data_tx", data_tx, modelBit(8'h3C, 2'b10, 2));
    checkOutput("mid-frame active_flag", active_flag, 1);
    reset_n = 1'b0;
    tick();
    checkOutput("abort data_tx", data_tx, 1);
    checkOutput("abort tx_ready", tx_ready, 1);
    checkOutput("abort active_flag", active_flag, 0);
    checkOutput("abort done_flag", done_flag, 0);
    reset_n = 1'b1;
    idleCycles(130);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
